// File: rtl/ysyx_25040111_axi_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4 arbiter.
// The state register doubles as the grant, so its encoding is fixed here.
package ysyx_25040111_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd0  = 2'd1,
    StRd1  = 2'd2,
    StWr1  = 2'd3
  } arb_state_e;

  localparam logic ArbM0 = 1'b0;
  localparam logic ArbM1 = 1'b1;

  localparam int unsigned DefaultTimeout = 4096;

endpackage

// File: rtl/ysyx_25040111_arb_rr2.sv
// Two-requester round-robin picker; on a tie the requester that did not win last time wins.
module ysyx_25040111_arb_rr2
  import ysyx_25040111_axi_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    if (req == 2'b11) begin
      gnt = (rr_last_q == ArbM1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    rr_last_d = rr_last_q;
    if (grant_en && (gnt != 2'b00)) begin
      rr_last_d = gnt[1] ? ArbM1 : ArbM0;
    end
  end

  // Reset to M1 so the IFU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= ArbM1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/ysyx_25040111_axi_arbiter.sv
// Shares one AXI4 slave port between the IFU (M0, read-only) and the LSU (M1, read/write),
// granting one whole transaction at a time, with a sticky watchdog on stalled transactions.
module ysyx_25040111_axi_arbiter
  import ysyx_25040111_axi_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                clk,
  input  logic                rst,
  // M0 (IFU) read
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  // M1 (LSU) read
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  // M1 (LSU) write
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  // Slave-side port
  output logic                io_master_awvalid,
  input  logic                io_master_awready,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [ID_W-1:0]     io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  output logic                io_master_wvalid,
  input  logic                io_master_wready,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  input  logic                io_master_bvalid,
  output logic                io_master_bready,
  input  logic [1:0]          io_master_bresp,
  input  logic [ID_W-1:0]     io_master_bid,
  output logic                io_master_arvalid,
  input  logic                io_master_arready,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [ID_W-1:0]     io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  input  logic                io_master_rvalid,
  output logic                io_master_rready,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic [1:0]          io_master_rresp,
  input  logic                io_master_rlast,
  input  logic [ID_W-1:0]     io_master_rid,
  output logic                busy,
  output logic                timeout
);

  localparam logic [31:0] TimeoutVal = 32'(TIMEOUT);

  arb_state_e  state_q, state_d;
  logic [1:0]  gnt;
  logic        grant_en;
  logic        ar_done_q, ar_done_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  assign grant_en = (state_q == StIdle);

  ysyx_25040111_arb_rr2 u_rr2 (
    .clk      (clk),
    .rst      (rst),
    .req      ({m1_awvalid | m1_arvalid, m0_arvalid}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (gnt[0]) begin
          state_d = StRd0;
        end else if (gnt[1]) begin
          state_d = m1_awvalid ? StWr1 : StRd1;
        end
      end
      StRd0, StRd1: begin
        if (io_master_rvalid && io_master_rready && io_master_rlast) state_d = StIdle;
      end
      StWr1: begin
        if (io_master_bvalid && io_master_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Done flags stop a master's next request from leaking into the current grant.
  always_comb begin
    ar_done_d = ar_done_q | (io_master_arvalid & io_master_arready);
    aw_done_d = aw_done_q | (io_master_awvalid & io_master_awready);
    w_done_d  = w_done_q  | (io_master_wvalid & io_master_wready & io_master_wlast);
    wd_cnt_d  = (wd_cnt_q != '1) ? wd_cnt_q + 32'd1 : wd_cnt_q;
    if (state_q == StIdle) begin
      ar_done_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      wd_cnt_d  = '0;
    end
    timeout_d = timeout_q;
    if ((TIMEOUT != 0) && (state_q != StIdle) && (wd_cnt_d == TimeoutVal)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign timeout = timeout_q;

  always_comb begin
    io_master_awvalid = 1'b0;
    io_master_awaddr  = '0;
    io_master_awid    = '0;
    io_master_awlen   = '0;
    io_master_awsize  = '0;
    io_master_awburst = '0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = '0;
    io_master_wstrb   = '0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_araddr  = '0;
    io_master_arid    = '0;
    io_master_arlen   = '0;
    io_master_arsize  = '0;
    io_master_arburst = '0;
    io_master_rready  = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;
    unique case (state_q)
      StRd0: begin
        io_master_arvalid = m0_arvalid & ~ar_done_q;
        io_master_araddr  = m0_araddr;
        io_master_arid    = m0_arid;
        io_master_arlen   = m0_arlen;
        io_master_arsize  = m0_arsize;
        io_master_arburst = m0_arburst;
        m0_arready        = io_master_arready & ~ar_done_q;
        m0_rvalid         = io_master_rvalid;
        m0_rdata          = io_master_rdata;
        m0_rresp          = io_master_rresp;
        m0_rlast          = io_master_rlast;
        m0_rid            = io_master_rid;
        io_master_rready  = m0_rready;
      end
      StRd1: begin
        io_master_arvalid = m1_arvalid & ~ar_done_q;
        io_master_araddr  = m1_araddr;
        io_master_arid    = m1_arid;
        io_master_arlen   = m1_arlen;
        io_master_arsize  = m1_arsize;
        io_master_arburst = m1_arburst;
        m1_arready        = io_master_arready & ~ar_done_q;
        m1_rvalid         = io_master_rvalid;
        m1_rdata          = io_master_rdata;
        m1_rresp          = io_master_rresp;
        m1_rlast          = io_master_rlast;
        m1_rid            = io_master_rid;
        io_master_rready  = m1_rready;
      end
      StWr1: begin
        io_master_awvalid = m1_awvalid & ~aw_done_q;
        io_master_awaddr  = m1_awaddr;
        io_master_awid    = m1_awid;
        io_master_awlen   = m1_awlen;
        io_master_awsize  = m1_awsize;
        io_master_awburst = m1_awburst;
        m1_awready        = io_master_awready & ~aw_done_q;
        io_master_wvalid  = m1_wvalid & ~w_done_q;
        io_master_wdata   = m1_wdata;
        io_master_wstrb   = m1_wstrb;
        io_master_wlast   = m1_wlast;
        m1_wready         = io_master_wready & ~w_done_q;
        m1_bvalid         = io_master_bvalid;
        m1_bresp          = io_master_bresp;
        m1_bid            = io_master_bid;
        io_master_bready  = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_arbiter.sv
// Scoreboard bench for the two-master AXI arbiter: the slave side is scripted per test and
// every response the masters should see is queued when the slave drives it.
module tb_ysyx_25040111_axi_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast;
  logic        m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wready;
  logic        io_master_wlast, io_master_bvalid, io_master_bready;
  logic [31:0] io_master_awaddr, io_master_wdata;
  logic [3:0]  io_master_awid, io_master_wstrb, io_master_bid;
  logic [7:0]  io_master_awlen;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst, io_master_bresp;
  logic        io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
  logic        io_master_rlast;
  logic [31:0] io_master_araddr, io_master_rdata;
  logic [3:0]  io_master_arid, io_master_rid;
  logic [7:0]  io_master_arlen;
  logic [2:0]  io_master_arsize;
  logic [1:0]  io_master_arburst, io_master_rresp;
  logic        busy, timeout;

  ysyx_25040111_axi_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .ID_W   (4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .busy(busy), .timeout(timeout)
  );

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    logic [63:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Channel codes: 0 = M0 R, 1 = M1 R, 2 = M1 B.
  function automatic logic [63:0] pk(input logic [3:0] ch, input logic [3:0] id,
                                     input logic last, input logic [1:0] resp,
                                     input logic [31:0] data);
    return {21'd0, ch, id, last, resp, data};
  endfunction

  task automatic sb_pop(input string tag, input logic [63:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_unexpected"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq(tag, got, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m0_rvalid && m0_rready) sb_pop("m0_r", pk(4'd0, m0_rid, m0_rlast, m0_rresp, m0_rdata));
      if (m1_rvalid && m1_rready) sb_pop("m1_r", pk(4'd1, m1_rid, m1_rlast, m1_rresp, m1_rdata));
      if (m1_bvalid && m1_bready) sb_pop("m1_b", pk(4'd2, m1_bid, 1'b0, m1_bresp, 32'd0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one AR and return `beats` R beats; `ch` is the master expected to own the grant.
  task automatic slave_read(input logic [3:0] ch, input int beats, input bit toggle,
                            input logic [31:0] base);
    int n;
    logic [1:0] who;
    exp_t e;
    n = 0;
    while (!io_master_arvalid && n < 20) begin
      tick();
      n++;
    end
    check_eq("ar_valid", 64'(io_master_arvalid), 64'd1);
    if (io_master_arvalid) begin
      check_eq("ar_len", 64'(io_master_arlen), 64'(beats - 1));
      io_master_arready = 1'b1;
      #1;
      who = {m1_arready, m0_arready};
      check_eq("ar_who", 64'(who), (ch == 4'd0) ? 64'd1 : 64'd2);
      tick();
      if (who[0]) m0_arvalid = 1'b0;
      if (who[1]) m1_arvalid = 1'b0;
      io_master_arready = 1'b0;
      for (int i = 0; i < beats; i++) begin
        if (toggle && (i % 2 == 1)) begin
          io_master_rvalid = 1'b0;
          tick();
        end
        io_master_rvalid = 1'b1;
        io_master_rdata  = base + 32'(i);
        io_master_rlast  = (i == beats - 1);
        io_master_rid    = 4'(i);
        io_master_rresp  = (i == beats - 1) ? 2'b10 : 2'b00;
        e.val = pk(ch, 4'(i), io_master_rlast, io_master_rresp, io_master_rdata);
        sb_q.push_back(e);
        if (i == beats - 1) begin
          #1;
          check_eq("grant_held", 64'(busy), 64'd1);
        end
        tick();
      end
      io_master_rvalid = 1'b0;
      io_master_rlast  = 1'b0;
    end
  endtask

  task automatic write_txn(input bit w_first);
    int n;
    exp_t e;
    m1_awvalid = 1'b1;
    m1_awaddr  = 32'h8000_0004;
    m1_awid    = 4'd2;
    m1_wvalid  = 1'b1;
    m1_wdata   = 32'h12;
    m1_wstrb   = 4'b0001;
    m1_wlast   = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    check_eq("wr_grant", 64'(busy), 64'd1);
    check_eq("aw_addr", 64'(io_master_awaddr), 64'h8000_0004);
    check_eq("w_strb", 64'(io_master_wstrb), 64'd1);
    m0_arvalid = 1'b1;
    m0_araddr  = 32'hA000_0000;
    m0_arlen   = 8'd0;
    if (w_first) begin
      io_master_wready = 1'b1;
      #1;
      check_eq("w_ready", 64'(m1_wready), 64'd1);
      tick();
      m1_wvalid = 1'b0;
      io_master_wready = 1'b0;
      io_master_awready = 1'b1;
      #1;
      check_eq("aw_ready", 64'(m1_awready), 64'd1);
      tick();
      m1_awvalid = 1'b0;
      io_master_awready = 1'b0;
    end else begin
      io_master_awready = 1'b1;
      #1;
      check_eq("aw_ready", 64'(m1_awready), 64'd1);
      tick();
      m1_awvalid = 1'b0;
      io_master_awready = 1'b0;
      io_master_wready = 1'b1;
      #1;
      check_eq("w_ready", 64'(m1_wready), 64'd1);
      tick();
      m1_wvalid = 1'b0;
      io_master_wready = 1'b0;
    end
    check_eq("no_m0_grant", 64'(io_master_arvalid), 64'd0);
    io_master_bvalid = 1'b1;
    io_master_bresp  = 2'b00;
    io_master_bid    = 4'd2;
    e.val = pk(4'd2, 4'd2, 1'b0, 2'b00, 32'd0);
    sb_q.push_back(e);
    tick();
    io_master_bvalid = 1'b0;
    #1;
    check_eq("b_one_cycle", 64'(m1_bvalid), 64'd0);
    check_eq("wr_done_idle", 64'(busy), 64'd0);
    slave_read(4'd0, 1, 1'b0, 32'hA5A5_0000);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
    {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
    {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
    {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast} = '0;
    {io_master_awready, io_master_wready, io_master_arready} = '0;
    {io_master_bvalid, io_master_bresp, io_master_bid} = '0;
    {io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid} = '0;
    m0_rready = 1'b1;
    m1_rready = 1'b1;
    m1_bready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_timeout", 64'(timeout), 64'd0);
    check_eq("rst_valids", 64'({io_master_arvalid, io_master_awvalid, io_master_wvalid}), 64'd0);
    check_eq("rst_readys", 64'({io_master_rready, io_master_bready, m0_arready, m1_arready}),
             64'd0);
    rst = 1'b0;

    // M0 alone: one-cycle grant latency.
    m0_arvalid = 1'b1;
    m0_araddr  = 32'h3000_0000;
    m0_arlen   = 8'd0;
    #1;
    check_eq("ar_lat0", 64'(io_master_arvalid), 64'd0);
    tick();
    check_eq("ar_lat1", 64'(io_master_arvalid), 64'd1);
    check_eq("ar_addr", 64'(io_master_araddr), 64'h3000_0000);
    slave_read(4'd0, 1, 1'b0, 32'hDEAD_BEEF);
    check_eq("rd_done_idle", 64'(busy), 64'd0);

    // Tie after M0 last won: M1 first, then M0 after one IDLE cycle.
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    m1_arlen   = 8'd0;
    slave_read(4'd1, 1, 1'b0, 32'h1111_0000);
    check_eq("bubble_busy", 64'(busy), 64'd0);
    check_eq("bubble_arv", 64'(io_master_arvalid), 64'd0);
    slave_read(4'd0, 1, 1'b0, 32'h2222_0000);

    // Tie right after reset: M0 first.
    pulse_rst();
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    slave_read(4'd0, 1, 1'b0, 32'h3333_0000);
    check_eq("bubble2_busy", 64'(busy), 64'd0);
    slave_read(4'd1, 1, 1'b0, 32'h4444_0000);

    write_txn(1'b1);
    write_txn(1'b0);

    // Burst with gaps between beats.
    m0_arvalid = 1'b1;
    m0_arlen   = 8'd3;
    slave_read(4'd0, 4, 1'b1, 32'hB000_0000);
    m0_arlen   = 8'd0;

    // Stray responses in IDLE.
    io_master_bvalid = 1'b1;
    io_master_bresp  = 2'b01;
    io_master_rvalid = 1'b1;
    #1;
    check_eq("stray_bready", 64'(io_master_bready), 64'd0);
    check_eq("stray_rready", 64'(io_master_rready), 64'd0);
    check_eq("stray_bvalid", 64'(m1_bvalid), 64'd0);
    tick();
    io_master_bvalid = 1'b0;
    io_master_rvalid = 1'b0;

    // Watchdog: slave never answers the read.
    pulse_rst();
    m1_arvalid = 1'b1;
    tick();
    check_eq("wd_grant", 64'(busy), 64'd1);
    check_eq("wd_init", 64'(timeout), 64'd0);
    io_master_arready = 1'b1;
    tick();
    m1_arvalid = 1'b0;
    io_master_arready = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      if (k == 7) check_eq("wd_before", 64'(timeout), 64'd0);
      if (k == 8) check_eq("wd_fire", 64'(timeout), 64'd1);
    end
    tick();
    tick();
    tick();
    check_eq("wd_sticky", 64'(timeout), 64'd1);
    check_eq("wd_no_abort", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_timeout", 64'(timeout), 64'd0);
    check_eq("mid_rst_outs", 64'({io_master_arvalid, io_master_rready, m1_arready}), 64'd0);
    rst = 1'b0;
    tick();

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
